screen_rotate_multi: RTL and testbench
======================================

Name: screen_rotate_multi

Overview:
Parametrised successor to the fixed ±90° frame rotator in the arcade video path. Captures native-orientation pixels into a double-buffered frame store and replays them in one of four orientations (0°, 90° CW, 90° CCW, 180°), with optional source mirror. Per-buffer geometry tracking keeps the output orientation glitch-free across mode changes. Sits between the arcade VGA resync stage and the video mixer/scaler input; output timing is scaler-only, not TV/VGA compliant.

Parameters:
WIDTH, 320, native active pixels per line
HEIGHT, 240, native active lines per frame
DEPTH, 8, pixel bit width
MARGIN, 4, black lines before and after active output region
HBL_LEN, 18, output horizontal blank length in ce_out cycles (>=12)
VBL_LINES, 16, output vertical blank length in lines (>=8)

Ports:
clk  in  1  video clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ce  in  1  input pixel enable
mode  in  2  0=none, 1=90 CW, 2=90 CCW, 3=180
flip  in  1  mirror source horizontally before rotation
video_in  in  DEPTH  input pixel
hblank  in  1  input horizontal blank
vblank  in  1  input vertical blank
ce_out  in  1  output pixel enable
video_out  out  DEPTH  output pixel
hsync  out  1  output hsync, active high
vsync  out  1  output vsync, active high
hblank_out  out  1  output horizontal blank
vblank_out  out  1  output vertical blank
frame_ok  out  1  at least one complete frame is displayable

Behaviour:
- Reset (async assert, sync release): video_out=0, hsync=0, vsync=0, hblank_out=1, vblank_out=1, frame_ok=0; write buffer=0; output counters xo=yo=0; write position x=y=0.
- RAM: 2*WIDTH*HEIGHT words, aw=$clog2(2*WIDTH*HEIGHT); buffer b occupies [b*W*H, (b+1)*W*H); one write and one read port, read latency 1, no read-during-write check.
- Write: pixel written when ce & ~hblank & ~vblank & x<WIDTH & y<HEIGHT; x increments per write. At each blank rising edge following >=1 write: x=0, y+=1. xf = flip ? WIDTH-1-x : xf = x.
- Write offset by latched mode: 0: y*W+xf; 3: (H-1-y)*W+(W-1-xf); 1: xf*H+(H-1-y); 2: (W-1-xf)*H+y. Incremental stepping (±1, ±H) allowed; results must match the formulas.
- mode/flip sampled only at vblank rising edge; they apply to the next input frame and are stored as that buffer's geometry tag.
- On vblank rising edge: the current buffer becomes "last complete" only if y==HEIGHT; otherwise it is discarded and rewritten. Write buffer toggles only when the frame was complete. x=y=0. frame_ok set on first complete frame.
- Output geometry from tag: modes 0/3 -> OW=WIDTH, OH=HEIGHT; modes 1/2 -> OW=HEIGHT, OH=WIDTH.
- Output timing advances only on ce_out: xo 0..OW+HBL_LEN-1, then xo=0, yo+=1; yo 0..2*MARGIN+OH+VBL_LINES-1, then wraps.
- At yo wrap (frame start), the read buffer and tag are latched from the last complete buffer. Geometry never changes mid-frame.
- Read address = rbuf*W*H + (yo-MARGIN)*OW + xo for MARGIN<=yo<MARGIN+OH and xo<OW.
- One-cycle-aligned pipeline: all outputs update on the cycle after the ce_out that produced them. video_out=RAM data inside active, else 0; 0 whenever frame_ok=0.
- hblank_out = xo>=OW; vblank_out = yo>=2*MARGIN+OH. MARGIN lines are non-blanked black.
- hsync=1 for xo in [OW+8, OW+10). vsync=1 for yo in [2*MARGIN+OH+4, 2*MARGIN+OH+6).
- Simultaneous events: vblank edge and output frame start on the same clk: the read side latches the newly completed buffer. Reader never latches the buffer being written.
- reset_n asserted mid-frame: immediate return to reset state. Partial frame is lost. frame_ok=0 until the next complete frame.

Test Plan:
- W=4,H=3,mode=0,flip=0, pixels 1..12 in, second frame in -> output lines 1,2,3,4 / 5,6,7,8 / 9,10,11,12, preceded and followed by 4 black lines; hblank_out=1 for 18 cycles per line.
- Same input, mode=1 -> OW=3, 4 lines: 9,5,1 / 10,6,2 / 11,7,3 / 12,8,4. mode=2 -> 4,8,12 / 3,7,11 / 2,6,10 / 1,5,9.
- mode=3 -> 12,11,10,9 / 8,7,6,5 / 4,3,2,1. mode=0,flip=1 -> 4,3,2,1 / 8,7,6,5 / 12,11,10,9.
- Toggle mode 0->1 mid input frame -> the displayed frame stays 4-wide until the output frame start after the next complete input frame, then 3-wide. No mixed-geometry frame.
- Input frame cut short with only 2 lines before vblank -> buffer not swapped; output keeps showing the prior frame. Before any complete frame: frame_ok=0, video_out=0.
- reset_n pulsed low mid active line -> all outputs at reset values within the same cycle; after release, timing restarts at xo=yo=0.

Source files
------------

// File: rtl/screen_rotate_multi.sv
// Double-buffered frame rotator: captures native-orientation pixels and replays
// them at 0/90 CW/90 CCW/180 degrees with per-buffer geometry for glitch-free mode changes.
module screen_rotate_multi #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int DEPTH     = 8,
  parameter int MARGIN    = 4,
  parameter int HBL_LEN   = 18,
  parameter int VBL_LINES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic             flip,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hblank,
  input  logic             vblank,
  input  logic             ce_out,
  output logic [DEPTH-1:0] video_out,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             frame_ok
);
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int WORDS = 2 * FRAME;
  localparam int AW    = $clog2(WORDS);
  localparam int DMAX  = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int XW    = $clog2(WIDTH + 1);
  localparam int YW    = $clog2(HEIGHT + 1);
  localparam int XOW   = $clog2(DMAX + HBL_LEN);
  localparam int YOW   = $clog2(2 * MARGIN + DMAX + VBL_LINES);

  // Write side state
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d, y_inc;
  logic          line_wr_q, line_wr_d;
  logic          hb_prev_q, hb_prev_d;
  logic          vb_prev_q, vb_prev_d;
  logic          wbuf_q, wbuf_d;
  logic [1:0]    wr_mode_q, wr_mode_d;
  logic          wr_flip_q, wr_flip_d;
  logic          last_q, last_d;
  logic [1:0]    disp_mode_q, disp_mode_d;
  logic          frame_ok_q, frame_ok_d;

  // Read side state
  logic [XOW-1:0] xo_q, xo_d;
  logic [YOW-1:0] yo_q, yo_d;
  logic           rbuf_q, rbuf_d;
  logic [1:0]     rmode_q, rmode_d;
  logic           active_q, active_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           hblank_q, hblank_d;
  logic           vblank_q, vblank_d;

  logic             hb_rise, vb_rise, line_end, we, re, act, rot;
  logic [AW-1:0]    waddr, raddr;
  logic [DEPTH-1:0] rd_data_q;
  logic [DEPTH-1:0] mem [WORDS];
  int               xi, yi, xf, wr_off;
  int               ow, oh, xoi, yoi;

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    line_wr_d   = line_wr_q;
    hb_prev_d   = hblank;
    vb_prev_d   = vblank;
    wbuf_d      = wbuf_q;
    wr_mode_d   = wr_mode_q;
    wr_flip_d   = wr_flip_q;
    last_d      = last_q;
    disp_mode_d = disp_mode_q;
    frame_ok_d  = frame_ok_q;

    hb_rise  = hblank & ~hb_prev_q;
    vb_rise  = vblank & ~vb_prev_q;
    line_end = (hb_rise | vb_rise) & line_wr_q;
    y_inc    = line_end ? (y_q + YW'(1)) : y_q;
    we       = ce & ~hblank & ~vblank & (x_q < XW'(WIDTH)) & (y_q < YW'(HEIGHT));

    xi = int'(x_q);
    yi = int'(y_q);
    xf = wr_flip_q ? (WIDTH - 1 - xi) : xi;
    case (wr_mode_q)
      2'd0:    wr_off = yi * WIDTH + xf;
      2'd1:    wr_off = xf * HEIGHT + (HEIGHT - 1 - yi);
      2'd2:    wr_off = (WIDTH - 1 - xf) * HEIGHT + yi;
      default: wr_off = (HEIGHT - 1 - yi) * WIDTH + (WIDTH - 1 - xf);
    endcase
    waddr = AW'((wbuf_q ? FRAME : 0) + wr_off);

    if (vb_rise) begin
      // Only a frame that reached the last line is published; a short one is rewritten in place.
      x_d       = '0;
      y_d       = '0;
      line_wr_d = 1'b0;
      wr_mode_d = mode;
      wr_flip_d = flip;
      if (y_inc == YW'(HEIGHT)) begin
        last_d      = wbuf_q;
        disp_mode_d = wr_mode_q;
        wbuf_d      = ~wbuf_q;
        frame_ok_d  = 1'b1;
      end
    end else if (line_end) begin
      x_d       = '0;
      y_d       = y_inc;
      line_wr_d = 1'b0;
    end else if (we) begin
      x_d       = x_q + XW'(1);
      line_wr_d = 1'b1;
    end
  end

  always_comb begin
    xo_d     = xo_q;
    yo_d     = yo_q;
    rbuf_d   = rbuf_q;
    rmode_d  = rmode_q;
    active_d = active_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;

    rot = rmode_q[0] ^ rmode_q[1];
    ow  = rot ? HEIGHT : WIDTH;
    oh  = rot ? WIDTH : HEIGHT;
    xoi = int'(xo_q);
    yoi = int'(yo_q);
    act = frame_ok_q && (yoi >= MARGIN) && (yoi < MARGIN + oh) && (xoi < ow);
    re  = ce_out & act;
    raddr = act ? AW'((rbuf_q ? FRAME : 0) + (yoi - MARGIN) * ow + xoi) : '0;

    if (ce_out) begin
      active_d = act;
      hblank_d = (xoi >= ow);
      vblank_d = (yoi >= 2 * MARGIN + oh);
      hsync_d  = (xoi >= ow + 8) && (xoi < ow + 10);
      vsync_d  = (yoi >= 2 * MARGIN + oh + 4) && (yoi < 2 * MARGIN + oh + 6);
      if (xoi == ow + HBL_LEN - 1) begin
        xo_d = '0;
        if (yoi == 2 * MARGIN + oh + VBL_LINES - 1) begin
          // Use the _d values so a frame completing on this very clock is picked up.
          yo_d    = '0;
          rbuf_d  = last_d;
          rmode_d = disp_mode_d;
        end else begin
          yo_d = yo_q + YOW'(1);
        end
      end else begin
        xo_d = xo_q + XOW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      line_wr_q   <= 1'b0;
      hb_prev_q   <= 1'b0;
      vb_prev_q   <= 1'b0;
      wbuf_q      <= 1'b0;
      wr_mode_q   <= 2'd0;
      wr_flip_q   <= 1'b0;
      last_q      <= 1'b0;
      disp_mode_q <= 2'd0;
      frame_ok_q  <= 1'b0;
      xo_q        <= '0;
      yo_q        <= '0;
      rbuf_q      <= 1'b0;
      rmode_q     <= 2'd0;
      active_q    <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      line_wr_q   <= line_wr_d;
      hb_prev_q   <= hb_prev_d;
      vb_prev_q   <= vb_prev_d;
      wbuf_q      <= wbuf_d;
      wr_mode_q   <= wr_mode_d;
      wr_flip_q   <= wr_flip_d;
      last_q      <= last_d;
      disp_mode_q <= disp_mode_d;
      frame_ok_q  <= frame_ok_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
      rbuf_q      <= rbuf_d;
      rmode_q     <= rmode_d;
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
    end
  end

  // Frame store: no reset so it maps onto block RAM; read data holds between ce_out pulses.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= video_in;
    if (re) rd_data_q <= mem[raddr];
  end

  assign video_out  = (active_q && frame_ok_q) ? rd_data_q : '0;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign hblank_out = hblank_q;
  assign vblank_out = vblank_q;
  assign frame_ok   = frame_ok_q;

endmodule

// File: tb/tb_screen_rotate_multi.sv
// Bench for screen_rotate_multi on a 4x3 frame: stimulus queues expected frames,
// a negedge monitor captures each displayed frame and compares it.
module tb_screen_rotate_multi;
  localparam int W = 4, H = 3, DW = 8, M = 4, HBL = 18, VBL = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          flip = 1'b0;
  logic [DW-1:0] video_in = '0;
  logic          hblank = 1'b1;
  logic          vblank = 1'b1;
  logic          ce_out = 1'b1;
  logic [DW-1:0] video_out;
  logic          hsync, vsync, hblank_out, vblank_out, frame_ok;

  always #5 clk = ~clk;

  screen_rotate_multi #(
    .WIDTH(W), .HEIGHT(H), .DEPTH(DW), .MARGIN(M), .HBL_LEN(HBL), .VBL_LINES(VBL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode), .flip(flip),
    .video_in(video_in), .hblank(hblank), .vblank(vblank), .ce_out(ce_out),
    .video_out(video_out), .hsync(hsync), .vsync(vsync),
    .hblank_out(hblank_out), .vblank_out(vblank_out), .frame_ok(frame_ok)
  );

  int checks = 0;
  int failures = 0;
  int exp_ow_q[$];
  int exp_oh_q[$];
  int exp_pix_q[$];

  // Hand-computed output rasters for input pixels 1..12 (row-major 4x3)
  int tbl [5][12] = '{
    '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12},    // mode 0
    '{9, 5, 1, 10, 6, 2, 11, 7, 3, 12, 8, 4},    // 90 CW
    '{4, 8, 12, 3, 7, 11, 2, 6, 10, 1, 5, 9},    // 90 CCW
    '{12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1},    // 180
    '{4, 3, 2, 1, 8, 7, 6, 5, 12, 11, 10, 9}     // mode 0 mirrored
  };

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_hb = 1'b1, prev_vb = 1'b1;
  bit   in_frame = 0, vs_pending = 0, hs_bad = 0, blank_bad = 0;
  int   line, px, hb_run, cur_ow, cur_oh, e;
  int   vs_cnt, vs_first, vs_ow, vcyc;
  int   fr [16];

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame   = 0;
      vs_pending = 0;
      prev_hb    = 1'b1;
      prev_vb    = 1'b1;
    end else begin
      if (prev_hb && !hblank_out && in_frame) check("hblank_len", hb_run, HBL);
      if (prev_vb && !vblank_out) begin
        if (vs_pending) begin
          check("vsync_len", vs_cnt, 2 * (vs_ow + HBL));
          check("vsync_start", vs_first, 4 * (vs_ow + HBL));
          vs_pending = 0;
        end
        if (exp_ow_q.size() > 0) begin
          cur_ow = exp_ow_q.pop_front();
          cur_oh = exp_oh_q.pop_front();
          for (int i = 0; i < cur_ow * cur_oh; i++) fr[i] = exp_pix_q.pop_front();
          in_frame  = 1;
          line      = 0;
          px        = 0;
          hs_bad    = 0;
          blank_bad = 0;
        end
      end
      if (!prev_vb && vblank_out) begin
        vcyc = 0; vs_cnt = 0; vs_first = -1;
        if (in_frame) begin
          check("frame_lines", line, 2 * M + cur_oh);
          check("hsync_pos", int'(hs_bad), 0);
          check("blank_black", int'(blank_bad), 0);
          in_frame   = 0;
          vs_pending = 1;
          vs_ow      = cur_ow;
        end
      end
      if (vblank_out) begin
        if (vsync) begin
          if (vs_first < 0) vs_first = vcyc;
          vs_cnt++;
        end
        vcyc++;
      end
      if (in_frame && !vblank_out) begin
        if (!hblank_out) begin
          e = (line < M || line >= M + cur_oh || px >= cur_ow) ? 0 : fr[(line - M) * cur_ow + px];
          check("pixel", int'(video_out), e);
          if (hsync) hs_bad = 1;
          px++;
        end
        if (!prev_hb && hblank_out) begin
          check("line_width", px, cur_ow);
          line++;
          px = 0;
        end
      end
      if (hblank_out) begin
        if (!prev_hb) hb_run = 0;
        if (in_frame) begin
          if (hsync != (hb_run >= 8 && hb_run < 10)) hs_bad = 1;
          if (video_out != '0) blank_bad = 1;
        end
        hb_run++;
      end
      prev_hb = hblank_out;
      prev_vb = vblank_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] m, input logic f, input int base,
                            input int nlines, input logic [1:0] mid_mode);
    vblank = 1'b0; hblank = 1'b1; tick();
    mode = m; flip = f; vblank = 1'b1; tick(); tick();
    vblank = 1'b0; tick(); tick();
    for (int y = 0; y < nlines; y++) begin
      hblank = 1'b0;
      for (int x = 0; x < W; x++) begin
        video_in = DW'(base + y * W + x);
        tick();
      end
      hblank = 1'b1; video_in = '0;
      if (y == 0) mode = mid_mode;
      repeat (4) tick();
    end
    vblank = 1'b1;
    repeat (3) tick();
  endtask

  task automatic push_exp(input int idx, input int ow, input int oh, input int off);
    exp_ow_q.push_back(ow);
    exp_oh_q.push_back(oh);
    for (int i = 0; i < 12; i++) exp_pix_q.push_back(tbl[idx][i] + off);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_ow_q.size() > 0 || in_frame) && c < 3000) begin
      tick();
      c++;
    end
    if (c >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: frame not displayed within 3000 cycles");
      exp_ow_q.delete(); exp_oh_q.delete(); exp_pix_q.delete();
    end
  endtask

  initial begin
    int nz, hz;
    bit found;
    logic hb1, vb1;

    repeat (3) tick();
    check("rst_video_out", int'(video_out), 0);
    check("rst_hsync", int'(hsync), 0);
    check("rst_vsync", int'(vsync), 0);
    check("rst_hblank_out", int'(hblank_out), 1);
    check("rst_vblank_out", int'(vblank_out), 1);
    check("rst_frame_ok", int'(frame_ok), 0);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // Short frame only: nothing displayable yet
    send_frame(2'd0, 1'b0, 1, 2, 2'd0);
    check("frame_ok_short", int'(frame_ok), 0);
    nz = 0;
    for (int c = 0; c < 700; c++) begin
      tick();
      if (video_out != '0) nz++;
    end
    check("dark_before_ok", nz, 0);

    send_frame(2'd0, 1'b0, 1, 3, 2'd0);
    check("frame_ok_first", int'(frame_ok), 1);
    push_exp(0, 4, 3, 0); drain();
    send_frame(2'd1, 1'b0, 1, 3, 2'd1); push_exp(1, 3, 4, 0); drain();
    send_frame(2'd2, 1'b0, 1, 3, 2'd2); push_exp(2, 3, 4, 0); drain();
    send_frame(2'd3, 1'b0, 1, 3, 2'd3); push_exp(3, 4, 3, 0); drain();
    send_frame(2'd0, 1'b1, 1, 3, 2'd0); push_exp(4, 4, 3, 0); drain();

    // Mode toggled mid input frame keeps the frame's own geometry
    send_frame(2'd0, 1'b0, 21, 3, 2'd1); push_exp(0, 4, 3, 20); drain();
    send_frame(2'd1, 1'b0, 21, 3, 2'd1); push_exp(1, 3, 4, 20); drain();

    // Truncated input frame leaves the display on the prior frame
    send_frame(2'd0, 1'b0, 21, 3, 2'd0); push_exp(0, 4, 3, 20); drain();
    send_frame(2'd0, 1'b0, 41, 2, 2'd0); push_exp(0, 4, 3, 20); drain();

    // Reset in the middle of an active line
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!hblank_out && !vblank_out && video_out != '0) begin
        found = 1;
        break;
      end
      tick();
    end
    check("found_active_px", int'(found), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_video_out", int'(video_out), 0);
    check("mid_rst_hsync", int'(hsync), 0);
    check("mid_rst_vsync", int'(vsync), 0);
    check("mid_rst_hblank_out", int'(hblank_out), 1);
    check("mid_rst_vblank_out", int'(vblank_out), 1);
    check("mid_rst_frame_ok", int'(frame_ok), 0);
    repeat (2) tick();
    @(negedge clk); reset_n = 1'b1;
    hz = 0; hb1 = 1'b1; vb1 = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c == 0) begin hb1 = hblank_out; vb1 = vblank_out; end
      if (!hblank_out) hz++;
    end
    check("restart_hblank0", int'(hb1), 0);
    check("restart_vblank0", int'(vb1), 0);
    check("restart_active_len", hz, W);
    check("restart_frame_ok", int'(frame_ok), 0);
    tick();

    send_frame(2'd2, 1'b0, 1, 3, 2'd2);
    check("frame_ok_after_rst", int'(frame_ok), 1);
    push_exp(2, 3, 4, 0); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
